// File: rtl/internal_bus_mux_hold.sv
// Registered one-hot bus selector: several drivers resolve as wired-AND, an undriven bus
// holds for HOLD_CYCLES edges and then returns to the precharge value. Optional macro: BUS_CONFLICT_CNT_EN.
module internal_bus_mux_hold #(
    parameter int WIDTH = 8,
    parameter int N_SRC = 3,
    parameter int HOLD_CYCLES = 2,
    parameter logic [WIDTH-1:0] PRECHARGE_VAL = {WIDTH{1'b1}}
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_SRC-1:0]       CNTL,
    input  logic [N_SRC*WIDTH-1:0] IN,
    input  logic                   CLR_CONFLICT,
    output logic [WIDTH-1:0]       OUT,
    output logic                   DRIVEN,
    output logic                   CONFLICT
`ifdef BUS_CONFLICT_CNT_EN
    ,
    output logic [7:0]             CONFLICT_CNT
`endif
);

    localparam int CW = ($clog2(HOLD_CYCLES + 1) > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        PRECHARGED = 2'd0,
        DRIVEN_S   = 2'd1,
        HOLDING    = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] out_nxt, bus_and;
    logic             any_drv, multi_drv;

    // Unselected slices are never read, so X on them cannot reach OUT.
    always_comb begin
        bus_and = '1;
        for (int k = 0; k < N_SRC; k++) begin
            if (CNTL[k]) bus_and = bus_and & IN[k*WIDTH +: WIDTH];
        end
    end

    assign any_drv   = |CNTL;
    assign multi_drv = (CNTL & (CNTL - N_SRC'(1))) != '0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = OUT;
        if (any_drv) begin
            out_nxt   = bus_and;
            cnt_nxt   = '0;
            state_nxt = DRIVEN_S;
        end else begin
            case (state)
                DRIVEN_S: begin
                    if (HOLD_CYCLES == 0) begin
                        out_nxt   = PRECHARGE_VAL;
                        state_nxt = PRECHARGED;
                    end else begin
                        cnt_nxt   = CW'(1);
                        state_nxt = HOLDING;
                    end
                end
                HOLDING: begin
                    if (cnt == HOLD_LAST) begin
                        out_nxt   = PRECHARGE_VAL;
                        cnt_nxt   = '0;
                        state_nxt = PRECHARGED;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= PRECHARGED;
            cnt   <= '0;
            OUT   <= PRECHARGE_VAL;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            OUT   <= out_nxt;
        end
    end

    assign DRIVEN = (state == DRIVEN_S);

    // A new conflict on the clearing edge wins over the clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)               CONFLICT <= 1'b0;
        else if (multi_drv)    CONFLICT <= 1'b1;
        else if (CLR_CONFLICT) CONFLICT <= 1'b0;
    end

`ifdef BUS_CONFLICT_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CONFLICT_CNT <= 8'd0;
        end else if (multi_drv) begin
            if (CLR_CONFLICT)               CONFLICT_CNT <= 8'd1;
            else if (CONFLICT_CNT != 8'hFF) CONFLICT_CNT <= CONFLICT_CNT + 8'd1;
        end else if (CLR_CONFLICT) begin
            CONFLICT_CNT <= 8'd0;
        end
    end
`else
    // Conflict counter not built; CONFLICT alone reports multi-driver edges.
`endif

endmodule

// File: tb/tb_internal_bus_mux_hold.sv
// Directed plus random bench for internal_bus_mux_hold against a run-length bus model.
// Also checks the conflict counter when BUS_CONFLICT_CNT_EN is defined.
module tb_internal_bus_mux_hold;

    localparam int WIDTH = 8;
    localparam int N_SRC = 3;
    localparam int HOLD  = 2;
    localparam logic [WIDTH-1:0] PRE = 8'hFF;

    logic                   CLK;
    logic                   RST;
    logic [N_SRC-1:0]       CNTL;
    logic [N_SRC*WIDTH-1:0] IN;
    logic                   CLR_CONFLICT;
    logic [WIDTH-1:0]       OUT;
    logic                   DRIVEN;
    logic                   CONFLICT;
`ifdef BUS_CONFLICT_CNT_EN
    logic [7:0]             CONFLICT_CNT;
`endif

    internal_bus_mux_hold #(
        .WIDTH(WIDTH), .N_SRC(N_SRC), .HOLD_CYCLES(HOLD), .PRECHARGE_VAL(PRE)
    ) dut (
        .CLK(CLK), .RST(RST), .CNTL(CNTL), .IN(IN), .CLR_CONFLICT(CLR_CONFLICT),
        .OUT(OUT), .DRIVEN(DRIVEN), .CONFLICT(CONFLICT)
`ifdef BUS_CONFLICT_CNT_EN
        , .CONFLICT_CNT(CONFLICT_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Model: value on the bus plus number of consecutive undriven edges seen.
    logic [WIDTH-1:0] m_out;
    int               m_run;
    logic             m_drv;
    logic             m_conf;
    int               m_cnt;

    task automatic model_reset();
        m_out  = PRE;
        m_run  = HOLD + 1;
        m_drv  = 1'b0;
        m_conf = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_edge(input logic [N_SRC-1:0] c, input logic [N_SRC*WIDTH-1:0] d, input logic clr);
        if (c != '0) begin
            m_out = PRE;
            for (int k = 0; k < N_SRC; k++)
                if (c[k]) m_out = m_out & d[k*WIDTH +: WIDTH];
            m_run = 0;
            m_drv = 1'b1;
        end else begin
            m_drv = 1'b0;
            if (m_run <= HOLD) m_run++;
            if (m_run > HOLD) m_out = PRE;
        end
        if ($countones(c) >= 2) begin
            m_conf = 1'b1;
            m_cnt  = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (clr) begin
            m_conf = 1'b0;
            m_cnt  = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out"}, 32'(OUT), 32'(m_out));
        chk({tag, ".driven"}, 32'(DRIVEN), 32'(m_drv));
        chk({tag, ".conflict"}, 32'(CONFLICT), 32'(m_conf));
`ifdef BUS_CONFLICT_CNT_EN
        chk({tag, ".cnt"}, 32'(CONFLICT_CNT), 32'(m_cnt));
`endif
    endtask

    task automatic step(input string tag, input logic [N_SRC-1:0] c, input logic clr);
        CNTL = c;
        CLR_CONFLICT = clr;
        @(posedge CLK);
        model_edge(c, IN, clr);
        #1;
        chk_all(tag);
    endtask

    initial begin
        RST = 1'b1;
        CNTL = '0;
        IN = '0;
        CLR_CONFLICT = 1'b0;
        model_reset();
        #2;
        chk_all("reset");
        chk("reset.out_ff", 32'(OUT), 32'h000000FF);
        #10 RST = 1'b0;

        // Source walk
        IN = {8'h03, 8'h02, 8'h01};
        step("walk0", 3'b001, 1'b0);
        chk("walk0.val", 32'(OUT), 32'h01);
        step("walk1", 3'b010, 1'b0);
        chk("walk1.val", 32'(OUT), 32'h02);
        step("walk2", 3'b100, 1'b0);
        chk("walk2.val", 32'(OUT), 32'h03);

        // Conflicts
        step("conf011", 3'b011, 1'b0);
        chk("conf011.val", 32'(OUT), 32'h00);
        step("conf110", 3'b110, 1'b0);
        chk("conf110.val", 32'(OUT), 32'h02);
        step("clr001", 3'b001, 1'b1);
        chk("clr001.conf", 32'(CONFLICT), 32'h0);
        step("clr101", 3'b101, 1'b1);
        chk("clr101.conf", 32'(CONFLICT), 32'h1);
        step("clr100", 3'b100, 1'b1);

        // Hold then decay
        step("hold1", 3'b000, 1'b0);
        chk("hold1.val", 32'(OUT), 32'h03);
        step("hold2", 3'b000, 1'b0);
        chk("hold2.val", 32'(OUT), 32'h03);
        step("decay", 3'b000, 1'b0);
        chk("decay.val", 32'(OUT), 32'hFF);
        step("decay_stay", 3'b000, 1'b0);

        // Hold aborted by a new driver
        step("abort_d", 3'b100, 1'b0);
        step("abort_h", 3'b000, 1'b0);
        step("abort_010", 3'b010, 1'b0);
        chk("abort.val", 32'(OUT), 32'h02);
        step("abort_h1", 3'b000, 1'b0);
        step("abort_h2", 3'b000, 1'b0);
        chk("abort_h2.val", 32'(OUT), 32'h02);
        step("abort_decay", 3'b000, 1'b0);

        // Reset asserted mid-hold
        step("mid_d", 3'b100, 1'b0);
        step("mid_h", 3'b000, 1'b0);
        #2 RST = 1'b1;
        model_reset();
        #1;
        chk_all("mid_rst");
        #2 RST = 1'b0;
        for (int i = 0; i < 5; i++) step("post_rst", 3'b000, 1'b0);

        // Random traffic, biased toward undriven runs
        for (int i = 0; i < 300; i++) begin
            logic [N_SRC-1:0] c;
            IN = {$urandom(), $urandom()} >> 8;
            c = ($urandom_range(0, 2) == 0) ? 3'b000 : N_SRC'($urandom());
            step("rand", c, ($urandom_range(0, 7) == 0));
        end

`ifdef BUS_CONFLICT_CNT_EN
        step("cnt_clr0", 3'b001, 1'b1);
        for (int i = 0; i < 3; i++) step("cnt3", 3'b011, 1'b0);
        chk("cnt3.val", 32'(CONFLICT_CNT), 32'd3);
        for (int i = 0; i < 300; i++) step("cnt_sat", 3'b111, 1'b0);
        chk("cnt_sat.val", 32'(CONFLICT_CNT), 32'd255);
        step("cnt_clr", 3'b000, 1'b1);
        chk("cnt_clr.val", 32'(CONFLICT_CNT), 32'd0);
        step("cnt_clr_conf", 3'b110, 1'b1);
        chk("cnt_clr_conf.val", 32'(CONFLICT_CNT), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
